// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// The entry struct below is sized for the default 9-bit PC / 32-bit instruction build.
package fetch_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Pointer width for a power-of-two FIFO, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO holding fetched {pc, instr} entries; flush beats push and pop.
// Push and pop may coincide at any fill level, including full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [ptr_width(DEPTH):0]  count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: owns the fetch PC, runs one outstanding req/ack read at a time,
// buffers returned words and presents them to decode; redirects flush everything.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus1,
    output logic [DATA_WIDTH-1:0] out_instr
);

    localparam int PW = ptr_width(DEPTH);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t  state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic          inflight;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW:0]   fifo_count;
    logic [PW+1:0] occupancy;
    logic          issue_ok;
    entry_t        push_entry;
    entry_t        head_entry;
    logic [EW-1:0] fifo_head;

    // Buffered plus in-flight words must stay below DEPTH so an ack can always be pushed.
    assign occupancy  = {1'b0, fifo_count} + (PW+2)'(inflight);
    assign issue_ok   = !redirect && !fifo_full && (occupancy < (PW+2)'(DEPTH));
    assign fifo_push  = (state == WAIT) && imem_ack && !redirect;
    assign fifo_pop   = out_ready && !fifo_empty;

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = imem_data;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            if (redirect) fetch_pc <= redirect_pc;
            unique case (state)
                IDLE: begin
                    if (issue_ok) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        inflight  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        inflight <= 1'b0;
                        if (!redirect) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
                    end else if (redirect) begin
                        // Request stays up until the memory answers; its data is then dropped.
                        state    <= DISCARD;
                        inflight <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    inflight <= 1'b0;
                end
            endcase
        end
    end

    assign head_entry   = fifo_head;
    assign out_valid    = !fifo_empty;
    assign out_pc       = out_valid ? head_entry.pc : '0;
    assign out_pc_plus1 = out_valid ? head_entry.pc + ADDR_WIDTH'(1) : '0;
    assign out_instr    = out_valid ? head_entry.instr : DATA_WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory responder.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_pc;
    logic [8:0]  out_pc_plus1;
    logic [31:0] out_instr;

    int n_checks = 0;
    int n_fail = 0;
    int ack_delay = 0;
    int req_cycles = 0;

    instruction_fetch_unit #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (9'h000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus1 (out_pc_plus1),
        .out_instr    (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return 32'hA5C3_0000 | {23'h0, a};
    endfunction

    // Memory: acks after ack_delay further cycles of req being high.
    always @(negedge clk) begin
        if (imem_req) begin
            if (req_cycles >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_data  = mem_word(imem_addr);
                req_cycles = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_data  = '0;
                req_cycles++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_data  = '0;
            req_cycles = 0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (reset && dut.fifo_push && dut.fifo_full && !dut.fifo_pop) begin
            n_fail++;
            $display("FAIL fifo_overflow: push into full FIFO at %0t", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_pc !== 9'h000) begin n_fail++; $display("FAIL reset_pc: got %h expected 000", out_pc); end
        n_checks++; if (out_pc_plus1 !== 9'h000) begin n_fail++; $display("FAIL reset_pc_plus1: got %h expected 000", out_pc_plus1); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    endtask

    task automatic test_basic();
        logic [8:0]  req_addr [4];
        logic [8:0]  pc_q [3];
        logic [8:0]  p1_q [3];
        logic [31:0] ins_q [3];
        int nreq = 0, npop = 0, gap_bad = 0, low_run = 0;
        int first_ack = -1, first_valid = -1;
        logic prev_req = 1'b0;
        foreach (req_addr[i]) req_addr[i] = '1;
        foreach (pc_q[i]) begin pc_q[i] = '1; p1_q[i] = '1; ins_q[i] = '1; end
        apply_reset();
        ack_delay = 2;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && !(nreq >= 4 && npop >= 3); cyc++) begin
            tick();
            if (imem_req && !prev_req) begin
                if (nreq < 4) req_addr[nreq] = imem_addr;
                if (nreq > 0 && low_run != 1) gap_bad++;
                nreq++;
            end
            low_run  = imem_req ? 0 : low_run + 1;
            prev_req = imem_req;
            if (imem_ack && first_ack < 0) first_ack = cyc;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready && npop < 3) begin
                pc_q[npop] = out_pc; p1_q[npop] = out_pc_plus1; ins_q[npop] = out_instr;
                npop++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (req_addr[i] !== 9'(i)) begin n_fail++; $display("FAIL basic_req_addr[%0d]: got %h expected %h", i, req_addr[i], 9'(i)); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (pc_q[i] !== 9'(i)) begin n_fail++; $display("FAIL basic_out_pc[%0d]: got %h expected %h", i, pc_q[i], 9'(i)); end
            n_checks++; if (p1_q[i] !== 9'(i + 1)) begin n_fail++; $display("FAIL basic_pc_plus1[%0d]: got %h expected %h", i, p1_q[i], 9'(i + 1)); end
            n_checks++; if (ins_q[i] !== mem_word(9'(i))) begin n_fail++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, ins_q[i], mem_word(9'(i))); end
        end
        n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL basic_req_gap: %0d gaps not one cycle, expected 0", gap_bad); end
        n_checks++; if (first_valid !== first_ack + 1) begin n_fail++; $display("FAIL basic_latency: valid at %0d expected %0d", first_valid, first_ack + 1); end
    endtask

    task automatic test_stall();
        logic [8:0] req_addr [4];
        logic [8:0] pop_pc [4];
        logic [8:0] resume_addr = '1;
        int nreq = 0, npop = 0;
        logic prev_req = 1'b0;
        foreach (req_addr[i]) begin req_addr[i] = '1; pop_pc[i] = '1; end
        apply_reset();
        ack_delay = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (imem_req && !prev_req) begin
                if (nreq < 4) req_addr[nreq] = imem_addr;
                nreq++;
            end
            prev_req = imem_req;
        end
        n_checks++; if (nreq !== 4) begin n_fail++; $display("FAIL stall_req_count: got %0d expected 4", nreq); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (req_addr[i] !== 9'(i)) begin n_fail++; $display("FAIL stall_req_addr[%0d]: got %h expected %h", i, req_addr[i], 9'(i)); end
        end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_idle: got %b expected 0", imem_req); end
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h000) begin n_fail++; $display("FAIL stall_head: valid %b pc %h expected 1/000", out_valid, out_pc); end
        out_ready = 1'b1;
        nreq = 0;
        prev_req = imem_req;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid && out_ready && npop < 4) begin pop_pc[npop] = out_pc; npop++; end
            tick();
            if (imem_req && !prev_req && nreq == 0) begin resume_addr = imem_addr; nreq++; end
            prev_req = imem_req;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (pop_pc[i] !== 9'(i)) begin n_fail++; $display("FAIL stall_pop_pc[%0d]: got %h expected %h", i, pop_pc[i], 9'(i)); end
        end
        n_checks++; if (resume_addr !== 9'h004) begin n_fail++; $display("FAIL stall_resume_addr: got %h expected 004", resume_addr); end
    endtask

    task automatic test_redirect_wait();
        logic found;
        apply_reset();
        ack_delay = 0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            tick();
            if (imem_ack && imem_addr == 9'h004) begin ack_delay = 3; found = 1'b1; end
        end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 9'h005) begin n_fail++; $display("FAIL rdw_wait_addr: found %b addr %h expected 005", found, imem_addr); end
        redirect = 1'b1;
        redirect_pc = 9'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h005) begin n_fail++; $display("FAIL rdw_hold1: req %b addr %h expected 1/005", imem_req, imem_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_flush: valid %b expected 0", out_valid); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h005) begin n_fail++; $display("FAIL rdw_hold2: req %b addr %h expected 1/005", imem_req, imem_addr); end
        tick();
        n_checks++; if (imem_ack !== 1'b1 || imem_addr !== 9'h005) begin n_fail++; $display("FAIL rdw_ack: ack %b addr %h expected 1/005", imem_ack, imem_addr); end
        tick();
        n_checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: req %b valid %b expected 0/0", imem_req, out_valid); end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 9'h100) begin n_fail++; $display("FAIL rdw_new_addr: found %b addr %h expected 100", found, imem_addr); end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (out_valid) found = 1'b1;
        end
        n_checks++; if (!found || out_pc !== 9'h100 || out_pc_plus1 !== 9'h101 || out_instr !== mem_word(9'h100)) begin
            n_fail++; $display("FAIL rdw_first_out: found %b pc %h p1 %h instr %h expected 100/101/%h", found, out_pc, out_pc_plus1, out_instr, mem_word(9'h100));
        end
    endtask

    task automatic test_redirect_ack_pop();
        logic found;
        apply_reset();
        ack_delay = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            tick();
            if (imem_ack && imem_addr == 9'h001) begin ack_delay = 2; found = 1'b1; end
        end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (imem_ack) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 9'h002 || out_valid !== 1'b1 || out_pc !== 9'h000) begin
            n_fail++; $display("FAIL rap_setup: found %b addr %h valid %b pc %h expected 1/002/1/000", found, imem_addr, out_valid, out_pc);
        end
        redirect = 1'b1;
        redirect_pc = 9'h020;
        out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rap_flush: valid %b req %b expected 0/0", out_valid, imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 9'h020) begin n_fail++; $display("FAIL rap_next_addr: req %b addr %h expected 1/020", imem_req, imem_addr); end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (out_valid) found = 1'b1;
        end
        n_checks++; if (!found || out_pc !== 9'h020 || out_instr !== mem_word(9'h020)) begin
            n_fail++; $display("FAIL rap_first_out: found %b pc %h instr %h expected 020/%h", found, out_pc, out_instr, mem_word(9'h020));
        end
    endtask

    task automatic test_wrap();
        logic [8:0]  req_addr [2];
        logic [8:0]  pc_q [2];
        logic [8:0]  p1_q [2];
        logic [31:0] ins0 = '1;
        int nreq = 0, npop = 0;
        logic prev_req = 1'b0;
        foreach (req_addr[i]) begin req_addr[i] = '1; pc_q[i] = '1; p1_q[i] = '1; end
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        redirect = 1'b1;
        redirect_pc = 9'h1FF;
        ack_delay = 1;
        out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_idle_redirect: req %b expected 0", imem_req); end
        for (int cyc = 0; cyc < 30 && !(nreq >= 2 && npop >= 2); cyc++) begin
            tick();
            if (imem_req && !prev_req) begin
                if (nreq < 2) req_addr[nreq] = imem_addr;
                nreq++;
            end
            prev_req = imem_req;
            if (out_valid && npop < 2) begin
                pc_q[npop] = out_pc; p1_q[npop] = out_pc_plus1;
                if (npop == 0) ins0 = out_instr;
                npop++;
            end
        end
        n_checks++; if (req_addr[0] !== 9'h1FF) begin n_fail++; $display("FAIL wrap_req0: got %h expected 1ff", req_addr[0]); end
        n_checks++; if (req_addr[1] !== 9'h000) begin n_fail++; $display("FAIL wrap_req1: got %h expected 000", req_addr[1]); end
        n_checks++; if (pc_q[0] !== 9'h1FF || p1_q[0] !== 9'h000) begin n_fail++; $display("FAIL wrap_out0: pc %h p1 %h expected 1ff/000", pc_q[0], p1_q[0]); end
        n_checks++; if (ins0 !== mem_word(9'h1FF)) begin n_fail++; $display("FAIL wrap_instr0: got %h expected %h", ins0, mem_word(9'h1FF)); end
        n_checks++; if (pc_q[1] !== 9'h000 || p1_q[1] !== 9'h001) begin n_fail++; $display("FAIL wrap_out1: pc %h p1 %h expected 000/001", pc_q[1], p1_q[1]); end
    endtask

    task automatic test_reset_midway();
        logic found;
        apply_reset();
        ack_delay = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            tick();
            if (imem_ack && imem_addr == 9'h002) begin ack_delay = 5; found = 1'b1; end
        end
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 9'h003 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_setup: found %b addr %h valid %b expected 1/003/1", found, imem_addr, out_valid);
        end
        reset = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_req_valid: req %b valid %b expected 0/0", imem_req, out_valid); end
        n_checks++; if (out_pc !== 9'h000 || out_pc_plus1 !== 9'h000 || out_instr !== 32'h0) begin
            n_fail++; $display("FAIL rmid_outputs: pc %h p1 %h instr %h expected 0/0/0", out_pc, out_pc_plus1, out_instr);
        end
        tick();
        reset = 1'b1;
        ack_delay = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        n_checks++; if (!found || imem_addr !== 9'h000) begin n_fail++; $display("FAIL rmid_restart_addr: found %b addr %h expected 000", found, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
